ras_spec_ctrl: RTL and testbench

Speculation controller for the return address stack. Turns fetch-stage call/return decode into push/pop commands on the stack, and keeps an undo journal of every speculative stack operation. On a branch mispredict it walks the journal backwards, one undo per cycle, restoring the stack to its state at the mispredicted branch. Sits between fetch/branch-resolution logic and the stack; fetch stalls while it recovers.

---
 rtl/ras_spec_ctrl_if.sv | 46 ++++
 rtl/ras_spec_ctrl.sv | 155 +++++++++++++++
 tb/tb_ras_spec_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ras_spec_ctrl_if.sv
// Bus between fetch/branch-resolution logic, the return address stack and
// the RAS speculation controller. The controller attaches through "slave";
// the surrounding logic (or a testbench) attaches through "master".
interface ras_spec_ctrl_if #(
    parameter int CKPT_DEPTH = 4
);
    localparam int CW = $clog2(CKPT_DEPTH);

    // Fetch-stage decode
    logic          fetch_valid;
    logic          fetch_is_call;
    logic          fetch_is_ret;
    logic [31:0]   fetch_pc;
    // Branch checkpoint / resolution
    logic          br_ckpt_en;
    logic          br_resolve_en;
    logic [CW-1:0] br_resolve_tag;
    logic          br_mispredict;
    // Stack status
    logic          ras_valid;
    logic [31:0]   ras_next_pc;
    // Controller outputs
    logic          ras_write_en;
    logic          ras_clear_en;
    logic [31:0]   ras_current_pc;
    logic [31:0]   ret_pred_pc;
    logic          ret_pred_valid;
    logic [CW-1:0] br_ckpt_tag;
    logic          fetch_stall;

    modport master (
        output fetch_valid, fetch_is_call, fetch_is_ret, fetch_pc,
        output br_ckpt_en, br_resolve_en, br_resolve_tag, br_mispredict,
        output ras_valid, ras_next_pc,
        input  ras_write_en, ras_clear_en, ras_current_pc,
        input  ret_pred_pc, ret_pred_valid, br_ckpt_tag, fetch_stall
    );

    modport slave (
        input  fetch_valid, fetch_is_call, fetch_is_ret, fetch_pc,
        input  br_ckpt_en, br_resolve_en, br_resolve_tag, br_mispredict,
        input  ras_valid, ras_next_pc,
        output ras_write_en, ras_clear_en, ras_current_pc,
        output ret_pred_pc, ret_pred_valid, br_ckpt_tag, fetch_stall
    );
endinterface

// File: rtl/ras_spec_ctrl.sv
// Return address stack speculation controller. Converts call/return decode
// into push/pop commands, journals every speculative stack operation while a
// branch checkpoint is live, and on a mispredict unwinds the journal one
// entry per cycle to restore the stack as it was at the branch.
module ras_spec_ctrl #(
    parameter int JRNL_DEPTH = 16,
    parameter int CKPT_DEPTH = 4
) (
    input  logic           clock,
    input  logic           reset,
    ras_spec_ctrl_if.slave bus
);
    localparam int JW = $clog2(JRNL_DEPTH);
    localparam int PW = JW + 1;              // extra bit separates full from empty
    localparam int CW = $clog2(CKPT_DEPTH);

    typedef enum logic {S_IDLE, S_RECOVER} state_t;

    state_t                r_state, w_state_nxt;
    logic [PW-1:0]         r_head, r_target;
    logic [CKPT_DEPTH-1:0] r_ck_valid, w_valid_nxt;
    logic [PW-1:0]         r_ck_idx [CKPT_DEPTH];
    logic [CW-1:0]         r_alloc, r_oldest;
    logic                  r_jr_pop  [JRNL_DEPTH];
    logic [31:0]           r_jr_data [JRNL_DEPTH];

    logic          w_idle, w_any_valid, w_jfull, w_mis, w_good, w_ck_blk, w_stall;
    logic          w_acc, w_ret, w_call, w_pop, w_jwr, w_ck_take, w_undo_pop;
    logic [PW-1:0] w_base, w_head_op, w_undo_ptr;
    logic [31:0]   w_undo_data;
    logic [CW-1:0] w_ds, w_da;

    // Decode of acceptance, stall and journaling conditions
    always_comb begin
        w_idle      = (r_state == S_IDLE);
        w_any_valid = |r_ck_valid;
        // Base lags while the oldest pointer walks over resolved slots.
        w_base      = r_ck_valid[r_oldest] ? r_ck_idx[r_oldest] : r_head;
        w_jfull     = ((r_head - w_base) == PW'(JRNL_DEPTH)) & w_any_valid;
        w_mis       = w_idle & bus.br_resolve_en & bus.br_mispredict
                      & r_ck_valid[bus.br_resolve_tag];
        w_good      = w_idle & bus.br_resolve_en & ~bus.br_mispredict;
        w_ck_blk    = bus.br_ckpt_en & r_ck_valid[r_alloc];
        // A mispredict wins over any same-cycle fetch op.
        w_stall     = ~w_idle | w_jfull | w_ck_blk | w_mis;
        w_acc       = w_idle & bus.fetch_valid & ~w_stall;
        w_ret       = w_acc & bus.fetch_is_ret;
        w_call      = w_acc & bus.fetch_is_call & ~bus.fetch_is_ret;
        w_pop       = w_ret & bus.ras_valid;
        w_jwr       = w_any_valid & (w_call | w_pop);
        w_head_op   = r_head + PW'(w_jwr);
        w_ck_take   = w_idle & bus.br_ckpt_en & ~w_stall;
        w_undo_ptr  = r_head - PW'(1);
        w_undo_pop  = r_jr_pop[w_undo_ptr[JW-1:0]];
        w_undo_data = r_jr_data[w_undo_ptr[JW-1:0]];
    end

    // Stack commands and prediction outputs; undo replay overrides in RECOVER
    always_comb begin
        bus.ras_write_en   = 1'b0;
        bus.ras_clear_en   = 1'b0;
        bus.ras_current_pc = 32'd0;
        bus.ret_pred_pc    = 32'd0;
        bus.ret_pred_valid = 1'b0;
        if (w_call) begin
            bus.ras_write_en   = 1'b1;
            bus.ras_current_pc = bus.fetch_pc;
        end
        if (w_ret) begin
            bus.ret_pred_pc    = bus.ras_next_pc;
            bus.ret_pred_valid = bus.ras_valid;
            bus.ras_clear_en   = bus.ras_valid;
        end
        if (!w_idle) begin
            if (w_undo_pop) begin
                // Stack stores operand+4, so re-push with saved-4.
                bus.ras_write_en   = 1'b1;
                bus.ras_current_pc = w_undo_data - 32'd4;
            end else begin
                bus.ras_clear_en   = 1'b1;
            end
        end
    end

    assign bus.fetch_stall = w_stall;
    assign bus.br_ckpt_tag = r_alloc;

    // Next-state decision for the recovery FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_mis && (r_ck_idx[bus.br_resolve_tag] != r_head))
                           w_state_nxt = S_RECOVER;
            S_RECOVER: if (w_undo_ptr == r_target)
                           w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Checkpoint valid update: resolve, squash younger on mispredict, allocate
    always_comb begin
        w_valid_nxt = r_ck_valid;
        w_ds        = '0;
        w_da        = r_alloc - bus.br_resolve_tag;
        if (w_good)
            w_valid_nxt[bus.br_resolve_tag] = 1'b0;
        if (w_mis) begin
            for (int s = 0; s < CKPT_DEPTH; s++) begin
                // Distance from the mispredicted tag in allocation order;
                // w_da == 0 means the ring is full and t is the oldest.
                w_ds = CW'(s) - bus.br_resolve_tag;
                if ((w_ds == '0) || (w_da == '0) || (w_ds < w_da))
                    w_valid_nxt[s] = 1'b0;
            end
        end
        if (w_ck_take)
            w_valid_nxt[r_alloc] = 1'b1;
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Journal pointers and checkpoint bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head     <= '0;
            r_target   <= '0;
            r_ck_valid <= '0;
            r_alloc    <= '0;
            r_oldest   <= '0;
        end else begin
            if (!w_idle)    r_head <= w_undo_ptr;
            else if (w_jwr) r_head <= w_head_op;
            if (w_mis) r_target <= r_ck_idx[bus.br_resolve_tag];
            r_ck_valid <= w_valid_nxt;
            if (w_mis)          r_alloc <= bus.br_resolve_tag + CW'(1);
            else if (w_ck_take) r_alloc <= r_alloc + CW'(1);
            if ((r_oldest != r_alloc) && !r_ck_valid[r_oldest])
                r_oldest <= r_oldest + CW'(1);
        end
    end

    // Journal entries and checkpoint journal positions
    always_ff @(posedge clock) begin
        if (w_jwr) begin
            r_jr_pop[r_head[JW-1:0]]  <= w_pop;
            r_jr_data[r_head[JW-1:0]] <= w_pop ? bus.ras_next_pc : bus.fetch_pc;
        end
        if (w_ck_take)
            r_ck_idx[r_alloc] <= w_head_op;
    end
endmodule

// File: tb/tb_ras_spec_ctrl.sv
// Testbench for ras_spec_ctrl: directed scenarios followed by random traffic,
// with an abstract reference model and a stack model driving ras_valid /
// ras_next_pc. Expected per-cycle outputs flow through a queue to a monitor.
module tb_ras_spec_ctrl;
    localparam int JD = 16;
    localparam int CD = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ras_spec_ctrl_if #(.CKPT_DEPTH(CD)) bus ();
    ras_spec_ctrl #(.JRNL_DEPTH(JD), .CKPT_DEPTH(CD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic        ce;
        logic [31:0] cpc;
        logic        pv;
        logic        chk_ppc;
        logic [31:0] ppc;
        logic [1:0]  tag;
        logic        stall;
        int          cyc;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cycn  = 0;

    // Reference model state: absolute journal positions, circular entry store
    bit          m_rec;
    int          m_head, m_target, m_alloc, m_old;
    bit          m_v   [CD];
    int          m_idx [CD];
    bit          j_pop [JD];
    logic [31:0] j_dat [JD];
    logic [31:0] stk[$];

    task automatic model_reset();
        m_rec = 0; m_head = 0; m_target = 0; m_alloc = 0; m_old = 0;
        for (int i = 0; i < CD; i++) begin m_v[i] = 0; m_idx[i] = 0; end
        stk.delete();
    endtask

    task automatic cyc(input bit rst, input bit fv, input bit call, input bit ret,
                       input logic [31:0] pc, input bit cken, input bit ren,
                       input int rtag, input bit mis);
        exp_t        e;
        bit          any, full, misacc, stall, acc, isret, iscall, pop, adv, stop;
        bit          rv;
        int          base, ent, s;
        logic [31:0] rnext;
        @(posedge clock);
        #1;
        rv    = (stk.size() > 0);
        rnext = rv ? stk[$] : $urandom;
        reset              = rst;
        bus.fetch_valid    = fv;
        bus.fetch_is_call  = call;
        bus.fetch_is_ret   = ret;
        bus.fetch_pc       = pc;
        bus.br_ckpt_en     = cken;
        bus.br_resolve_en  = ren;
        bus.br_resolve_tag = 2'(rtag);
        bus.br_mispredict  = mis;
        bus.ras_valid      = rv;
        bus.ras_next_pc    = rnext;

        e = '{we: 0, ce: 0, cpc: 0, pv: 0, chk_ppc: 0, ppc: 0, tag: 0, stall: 0, cyc: cycn};
        e.tag = 2'(m_alloc);
        any = 0;
        for (int i = 0; i < CD; i++) any |= m_v[i];
        base = m_v[m_old] ? m_idx[m_old] : m_head;
        adv  = (m_old != m_alloc) && !m_v[m_old];

        if (m_rec) begin
            ent = (m_head - 1) % JD;
            e.stall = 1;
            if (j_pop[ent]) begin e.we = 1; e.cpc = j_dat[ent] - 32'd4; end
            else            e.ce = 1;
            m_head--;
            if (m_head == m_target) m_rec = 0;
        end else begin
            misacc  = ren && mis && m_v[rtag];
            full    = any && ((m_head - base) == JD);
            stall   = misacc || full || (cken && m_v[m_alloc]);
            e.stall = stall;
            acc    = fv && !stall;
            isret  = acc && ret;
            iscall = acc && call && !ret;
            pop    = isret && rv;
            if (iscall) begin e.we = 1; e.cpc = pc; end
            if (isret) begin
                e.chk_ppc = 1; e.ppc = rnext; e.pv = rv; e.ce = rv;
            end
            if (any && (iscall || pop)) begin
                j_pop[m_head % JD] = pop;
                j_dat[m_head % JD] = pop ? rnext : pc;
                m_head++;
            end
            if (ren && !mis) m_v[rtag] = 0;
            if (cken && !stall) begin
                m_v[m_alloc]   = 1;
                m_idx[m_alloc] = m_head;
                m_alloc        = (m_alloc + 1) % CD;
            end
            if (misacc) begin
                m_target = m_idx[rtag];
                stop = 0;
                for (int k = 0; k < CD; k++) begin
                    s = (rtag + k) % CD;
                    if (k > 0 && s == m_alloc) stop = 1;
                    if (!stop) m_v[s] = 0;
                end
                m_alloc = (rtag + 1) % CD;
                if (m_head != m_target) m_rec = 1;
            end
        end
        if (adv) m_old = (m_old + 1) % CD;

        if (e.we) stk.push_back(e.cpc + 32'd4);
        if (e.ce && stk.size() > 0) void'(stk.pop_back());
        if (rst) model_reset();
        expq.push_back(e);
        cycn++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    endtask

    task automatic do_rst();
        cyc(1, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    endtask

    // Monitor: compares every DUT cycle against the queued expectation
    exp_t me;
    bit   ok;
    always @(negedge clock) begin
        if (expq.size() > 0) begin
            me = expq.pop_front();
            n_cmp++;
            ok = (bus.ras_write_en === me.we) && (bus.ras_clear_en === me.ce) &&
                 (bus.ras_current_pc === me.cpc) && (bus.ret_pred_valid === me.pv) &&
                 (!me.chk_ppc || (bus.ret_pred_pc === me.ppc)) &&
                 (bus.br_ckpt_tag === me.tag) && (bus.fetch_stall === me.stall);
            if (!ok) begin
                n_bad++;
                $display("FAIL outputs cyc %0d: got we=%0b ce=%0b cpc=%h pv=%0b ppc=%h tag=%0d stall=%0b; expected we=%0b ce=%0b cpc=%h pv=%0b ppc=%h(chk %0b) tag=%0d stall=%0b",
                         me.cyc, bus.ras_write_en, bus.ras_clear_en, bus.ras_current_pc,
                         bus.ret_pred_valid, bus.ret_pred_pc, bus.br_ckpt_tag, bus.fetch_stall,
                         me.we, me.ce, me.cpc, me.pv, me.ppc, me.chk_ppc, me.tag, me.stall);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.fetch_valid = 0; bus.fetch_is_call = 0; bus.fetch_is_ret = 0; bus.fetch_pc = 0;
        bus.br_ckpt_en = 0; bus.br_resolve_en = 0; bus.br_resolve_tag = 0;
        bus.br_mispredict = 0; bus.ras_valid = 0; bus.ras_next_pc = 0;
        model_reset();
        repeat (2) @(posedge clock);

        // Reset state, call/ret pass-through, ret on empty stack
        do_rst();
        cyc(0, 1, 1, 0, 32'h100, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 32'h104, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 32'h108, 0, 0, 0, 0);

        // Checkpoint, two calls, ret, mispredict -> three-step undo
        cyc(0, 0, 0, 0, 32'h0,   1, 0, 0, 0);
        cyc(0, 1, 1, 0, 32'h200, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 32'h300, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 32'h310, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 32'h0,   0, 1, 0, 1);
        idle(4);

        // Tags 0,1,2; mispredict tag 1; reallocation yields tag 2; resolve 0
        do_rst();
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 32'h0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 32'h0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 32'h0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 32'h0, 0, 1, 0, 0);
        idle(3);

        // Journal full with a checkpoint open, then resolve releases the stall
        do_rst();
        cyc(0, 0, 0, 0, 32'h0, 1, 0, 0, 0);
        for (int i = 0; i < 17; i++) cyc(0, 1, 1, 0, 32'h1000 + 32'(i * 4), 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 32'h1040, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 32'h1040, 0, 0, 0, 0);
        idle(2);

        // Mispredict beats a same-cycle call; reset in the middle of RECOVER
        do_rst();
        cyc(0, 0, 0, 0, 32'h0,   1, 0, 0, 0);
        cyc(0, 1, 1, 0, 32'h500, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 32'h600, 0, 1, 0, 1);
        idle(2);
        cyc(0, 0, 0, 0, 32'h0,   1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 32'h700 + 32'(i * 16), 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 32'h0, 0, 1, 1, 1);
        idle(1);
        do_rst();
        idle(3);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 149) == 0),
                ($urandom_range(0, 3) != 0),
                $urandom_range(0, 1) == 1,
                ($urandom_range(0, 2) == 0),
                $urandom & 32'hFFFF_FFFC,
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0),
                $urandom_range(0, 3),
                ($urandom_range(0, 2) == 0));
        end
        idle(2);

        @(posedge clock);
        @(negedge clock);
        #1;
        if (expq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
